// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the fetch address, talks to instruction memory over
// req/ready, and feeds the IF/ID register through an output slot backed by a one-entry skid.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        ex_b_flag,
    input  logic [31:0] ex_b_addr,
    input  logic        id_b_flag,
    input  logic [31:0] id_b_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {IDLE, FETCH, KILL, FULL} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    state_t      state, state_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] redir_addr, redir_addr_n;
    ent_t        slot, slot_n, skid, skid_n;
    logic        slot_v, slot_v_n, skid_v, skid_v_n;

    logic        redir, consume;
    logic [31:0] target;

    // Only the IF/ID stall bit matters to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

    assign redir    = ex_b_flag | id_b_flag;
    assign target   = ex_b_flag ? ex_b_addr : id_b_addr;
    assign consume  = slot_v & ~stall[1];

    assign mem_req  = (state == FETCH) || (state == KILL);
    assign mem_addr = req_addr;
    assign if_pc    = slot.pc;
    assign if_inst  = slot.inst;

    always_comb begin
        state_n      = state;
        req_addr_n   = req_addr;
        redir_addr_n = redir_addr;
        slot_n       = slot;
        slot_v_n     = slot_v;
        skid_n       = skid;
        skid_v_n     = skid_v;

        if (consume) begin
            slot_n   = '0;
            slot_v_n = 1'b0;
        end
        // A redirect squashes everything already fetched, stalled or not.
        if (redir) begin
            slot_n   = '0;
            slot_v_n = 1'b0;
            skid_n   = '0;
            skid_v_n = 1'b0;
        end

        case (state)
            IDLE: begin
                state_n = FETCH;
                if (redir) req_addr_n = target;
            end
            FETCH: begin
                if (redir) begin
                    if (mem_ready) begin
                        req_addr_n = target;
                    end else begin
                        // Request cannot be withdrawn; remember the target and drop its data.
                        redir_addr_n = target;
                        state_n      = KILL;
                    end
                end else if (mem_ready) begin
                    req_addr_n = req_addr + 32'd4;
                    if (!slot_v || consume) begin
                        slot_n   = '{pc: req_addr, inst: mem_rdata};
                        slot_v_n = 1'b1;
                    end else begin
                        skid_n   = '{pc: req_addr, inst: mem_rdata};
                        skid_v_n = 1'b1;
                        state_n  = FULL;
                    end
                end
            end
            KILL: begin
                if (redir) redir_addr_n = target;
                if (mem_ready) begin
                    req_addr_n = redir ? target : redir_addr;
                    state_n    = FETCH;
                end
            end
            FULL: begin
                if (redir) begin
                    req_addr_n = target;
                    state_n    = FETCH;
                end else if (consume) begin
                    slot_n   = skid;
                    slot_v_n = 1'b1;
                    skid_n   = '0;
                    skid_v_n = 1'b0;
                    state_n  = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= RESET_PC;
            redir_addr <= '0;
            slot       <= '0;
            slot_v     <= 1'b0;
            skid       <= '0;
            skid_v     <= 1'b0;
        end else begin
            state      <= state_n;
            req_addr   <= req_addr_n;
            redir_addr <= redir_addr_n;
            slot       <= slot_n;
            slot_v     <= slot_v_n;
            skid       <= skid_n;
            skid_v     <= skid_v_n;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: wait-state memory responder, queue-based fetch model checked every
// cycle, and directed scenarios with literal expectations.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        ex_b_flag, id_b_flag;
    logic [31:0] ex_b_addr, id_b_addr;
    logic        mem_req, mem_ready;
    logic [31:0] mem_addr, mem_rdata;
    logic [31:0] if_pc, if_inst;

    int unsigned waits;
    int unsigned wcnt;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_b_flag(ex_b_flag), .ex_b_addr(ex_b_addr),
        .id_b_flag(id_b_flag), .id_b_addr(id_b_addr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    // Memory: completes a request after `waits` wait cycles; data is address-tagged.
    assign mem_ready = mem_req && (wcnt >= waits);
    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (rst)            wcnt <= 0;
        else if (mem_ready) wcnt <= 0;
        else if (mem_req)   wcnt <= wcnt + 1;
    end

    // Model: a queue of fetched-but-unconsumed instructions (head = presented one),
    // the next/outstanding fetch address, and a pending wrong-path drop.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } m_ent_t;

    m_ent_t      m_q[$];
    logic        m_init = 1'b0;
    logic        m_started;
    logic        m_drop;
    logic [31:0] m_addr, m_drop_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        logic        s_rst, s_st1, s_ex, s_id, s_rdy, s_redir, outst, e_req;
        logic [31:0] s_exa, s_ida, s_rd, tgt;
        #1;
        s_rst = rst; s_st1 = stall[1];
        s_ex = ex_b_flag; s_exa = ex_b_addr;
        s_id = id_b_flag; s_ida = id_b_addr;
        s_rdy = mem_ready; s_rd = mem_rdata;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        s_redir = s_ex || s_id;
        tgt = s_ex ? s_exa : s_ida;
        if (s_rst) begin
            m_init = 1'b1;
            m_started = 1'b0;
            m_drop = 1'b0;
            m_drop_tgt = '0;
            m_addr = 32'h0000_0000;
            m_q.delete();
        end else if (m_init) begin
            outst = m_started && (m_q.size() < 2);
            if (!m_started) begin
                m_started = 1'b1;
                if (s_redir) m_addr = tgt;
            end else if (s_redir) begin
                m_q.delete();
                if (outst && !s_rdy) begin
                    m_drop = 1'b1;
                    m_drop_tgt = tgt;
                end else begin
                    m_drop = 1'b0;
                    m_addr = tgt;
                end
            end else begin
                if (m_q.size() > 0 && !s_st1) void'(m_q.pop_front());
                if (outst && s_rdy) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                        m_addr = m_drop_tgt;
                    end else begin
                        m_q.push_back('{pc: m_addr, inst: s_rd});
                        m_addr = m_addr + 32'd4;
                    end
                end
            end
        end
        if (m_init) begin
            e_req = m_started && (m_q.size() < 2);
            chk("mdl_req", 32'(mem_req), 32'(e_req));
            if (e_req) chk("mdl_addr", mem_addr, m_addr);
            chk("mdl_pc", if_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
            chk("mdl_inst", if_inst, (m_q.size() > 0) ? m_q[0].inst : 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; stall = '0; waits = 0;
        ex_b_flag = 1'b0; ex_b_addr = '0; id_b_flag = 1'b0; id_b_addr = '0;
        cycle(); cycle();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);

        // Zero-wait streaming from RESET_PC
        rst = 1'b0;
        cycle();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        chk("first_bubble", if_pc, 32'h0);
        cycle(); chk("pc0", if_pc, 32'h0); chk("inst0", if_inst, 32'hA5A5_0000);
        cycle(); chk("pc4", if_pc, 32'h4); chk("inst4", if_inst, 32'hA5A5_0004);
        cycle(); chk("pc8", if_pc, 32'h8); chk("inst8", if_inst, 32'hA5A5_0008);

        // Stall IF/ID for three cycles while 8 is presented
        stall = 6'b000010;
        cycle(); chk("stall_pc1", if_pc, 32'h8); chk("stall_req1", 32'(mem_req), 32'd0);
        cycle(); chk("stall_pc2", if_pc, 32'h8); chk("stall_req2", 32'(mem_req), 32'd0);
        cycle(); chk("stall_pc3", if_pc, 32'h8);
        stall = '0;
        cycle(); chk("rel_pc12", if_pc, 32'hC); chk("rel_addr", mem_addr, 32'h10);
        cycle(); chk("rel_pc16", if_pc, 32'h10); chk("rel_inst16", if_inst, 32'hA5A5_0010);

        // Two wait states: ID redirect to 0x10 while 0x14 is outstanding
        waits = 2; id_b_flag = 1'b1; id_b_addr = 32'h10;
        cycle(); id_b_flag = 1'b0;
        chk("kill_hold", mem_addr, 32'h14); chk("kill_bubble", if_pc, 32'h0);
        cycle();
        cycle(); chk("req_0x10", mem_addr, 32'h10);
        // EX redirect to 0x100 with 0x10 outstanding
        ex_b_flag = 1'b1; ex_b_addr = 32'h100;
        cycle(); ex_b_flag = 1'b0;
        chk("hold10_a", mem_addr, 32'h10); chk("req_kill", 32'(mem_req), 32'd1);
        cycle(); chk("hold10_b", mem_addr, 32'h10); chk("no10_a", if_inst, 32'h0);
        cycle(); chk("req_0x100", mem_addr, 32'h100); chk("no10_b", if_inst, 32'h0);
        waits = 0;
        cycle(); chk("pc100", if_pc, 32'h100); chk("inst100", if_inst, 32'hA5A5_0100);

        // Both redirects together: EX wins, slot cleared
        ex_b_flag = 1'b1; ex_b_addr = 32'h200; id_b_flag = 1'b1; id_b_addr = 32'h300;
        cycle(); ex_b_flag = 1'b0; id_b_flag = 1'b0;
        chk("both_addr", mem_addr, 32'h200);
        chk("both_pc", if_pc, 32'h0); chk("both_inst", if_inst, 32'h0);
        cycle(); chk("pc200", if_pc, 32'h200);

        // Redirect coinciding with mem_ready: no KILL cycle
        id_b_flag = 1'b1; id_b_addr = 32'h20;
        cycle(); id_b_flag = 1'b0;
        chk("req_0x20", mem_addr, 32'h20);
        ex_b_flag = 1'b1; ex_b_addr = 32'h40;
        cycle(); ex_b_flag = 1'b0;
        chk("nokill_addr", mem_addr, 32'h40); chk("nokill_req", 32'(mem_req), 32'd1);
        chk("drop20", if_pc, 32'h0);
        cycle(); chk("pc40", if_pc, 32'h40); chk("inst40", if_inst, 32'hA5A5_0040);

        // Reset in the middle of a wait on 0x8
        id_b_flag = 1'b1; id_b_addr = 32'h8;
        cycle(); id_b_flag = 1'b0; waits = 2;
        chk("req_0x8", mem_addr, 32'h8);
        cycle(); chk("wait_0x8", mem_addr, 32'h8);
        rst = 1'b1;
        cycle();
        chk("mrst_req", 32'(mem_req), 32'd0);
        chk("mrst_pc", if_pc, 32'h0); chk("mrst_inst", if_inst, 32'h0);
        rst = 1'b0; waits = 0;
        cycle(); chk("restart_addr", mem_addr, 32'h0); chk("restart_req", 32'(mem_req), 32'd1);
        cycle(); chk("restart_pc", if_pc, 32'h0); chk("restart_inst", if_inst, 32'hA5A5_0000);

        // Address wrap
        id_b_flag = 1'b1; id_b_addr = 32'hFFFF_FFFC;
        cycle(); id_b_flag = 1'b0;
        chk("wrap_req", mem_addr, 32'hFFFF_FFFC);
        cycle(); chk("wrap_pc", if_pc, 32'hFFFF_FFFC); chk("wrap_next", mem_addr, 32'h0);
        cycle(); chk("wrap_pc0", if_pc, 32'h0); chk("wrap_inst0", if_inst, 32'hA5A5_0000);

        // Mixed traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            stall = 6'($urandom);
            waits = $urandom_range(0, 2);
            ex_b_flag = ($urandom_range(0, 9) == 0);
            ex_b_addr = $urandom & 32'hFFFF_FFFC;
            id_b_flag = ($urandom_range(0, 7) == 0);
            id_b_addr = $urandom & 32'hFFFF_FFFC;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end of the RISC-V pipeline. It drives the IF side of the IF/ID pipeline register. It keeps the fetch address and issues requests to instruction memory over a request/ready handshake. It presents exactly one fetched instruction per consumption, or a zero bubble, on `if_pc`/`if_inst`, and it handles stalls and branch redirects without losing, duplicating or leaking wrong-path instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1, clock, all state changes on rising edge
- `rst` in 1, synchronous, active-high reset
- `stall` in 6, pipeline stall vector; `stall[1]=1` means IF/ID does not consume `if_pc`/`if_inst` this cycle
- `ex_b_flag` in 1, EX branch/jump redirect
- `ex_b_addr` in 32, EX redirect target
- `id_b_flag` in 1, ID branch/jump redirect
- `id_b_addr` in 32, ID redirect target
- `mem_req` out 1, instruction read request
- `mem_addr` out 32, request address (`req_addr` register)
- `mem_rdata` in 32, read data, valid when `mem_ready=1`
- `mem_ready` in 1, one-cycle completion pulse for the outstanding request
- `if_pc` out 32, registered PC of the presented instruction, 0 when empty
- `if_inst` out 32, registered instruction, 0 (bubble) when empty

## Operation
- Storage:
  - `req_addr`: outstanding/next fetch address
  - `redir_addr`
  - output slot: `if_pc`, `if_inst`, `slot_v`
  - one-entry skid: `skid_pc`, `skid_inst`, `skid_v`
  - state ∈ {IDLE, FETCH, KILL, FULL}
- Memory protocol: once `mem_req=1`, `mem_req` and `mem_addr` stay stable until `mem_ready`. A request is never withdrawn except by `rst`.
- `mem_req` = (state==FETCH || state==KILL). It is combinational from state.
- Consume: `slot_v && !stall[1]` at an edge. The slot is cleared (outputs→0) unless it is reloaded in the same edge.
- Redirect: `ex_b_flag || id_b_flag`. The target is `ex_b_addr` if `ex_b_flag`, else `id_b_addr`; EX has priority. On redirect, slot and skid are cleared (outputs→0) regardless of `stall`.
- IDLE: next state is FETCH. Redirect loads `req_addr<=target`.
- FETCH, with a redirect:
  - `mem_ready=1`: `req_addr<=target`, stay in FETCH, data dropped.
  - `mem_ready=0`: `redir_addr<=target`, go to KILL.
- FETCH, with no redirect and `mem_ready=1`:
  - If slot empty or consumed: slot <= {`req_addr`, `mem_rdata`}, `req_addr+=4`, stay in FETCH.
  - Otherwise: skid <= {`req_addr`, `mem_rdata`}, `req_addr+=4`, go to FULL.
- KILL:
  - Redirect: `redir_addr<=target`.
  - On `mem_ready`: data dropped, `req_addr<=`(redirect this cycle ? target : `redir_addr`), go to FETCH.
- FULL (no request):
  - Redirect: clear slot and skid, `req_addr<=target`, go to FETCH.
  - Else, when the slot is consumed: slot<=skid, `skid_v<=0`, go to FETCH.
- Address arithmetic is modulo 2^32; `0xFFFF_FFFC+4` wraps to 0.
- Reset:
  - `req_addr=RESET_PC`, `redir_addr=0`
  - `if_pc=0`, `if_inst=0`, `slot_v=0`, `skid_v=0`
  - state=IDLE, `mem_req=0`
- Reset during an outstanding request abandons it. Instruction memory shares `rst`.

## Timing
- First request occurs the cycle after `rst` deasserts.
- With zero-wait memory (`mem_ready` in the request cycle), the instruction appears on `if_inst` one cycle after the request. Throughput is one instruction per cycle while `stall[1]=0`.
- Wait-state memory: the slot is empty (bubble) for each wait cycle.
- Redirect at edge N with no outstanding request: the target request is visible in cycle N+1. With zero-wait memory, the target instruction is presented in cycle N+2.
- Redirect with a request outstanding: the target request starts the cycle after the old `mem_ready`.
- `stall[1]` held: slot holds its value, the skid absorbs at most one response, and `mem_req` drops the cycle after the skid fills.
- A redirect always overrides stall, consume and memory data in the same cycle.

## Test plan
- Reset, `RESET_PC=0`, zero-wait memory with `mem_rdata=addr^32'hA5A5_0000`, `stall=0`:
  - `mem_req` rises 1 cycle after reset.
  - `if_pc` steps 0,4,8,12 on consecutive cycles with matching `if_inst`.
- Streaming, then `stall[1]=1` for 3 cycles while `if_pc=8`:
  - `if_pc` holds 8.
  - 12 is captured in the skid.
  - `mem_req=0` from the next cycle.
  - After release, `if_pc` goes 12,16 with no gap and no duplicate.
- 2-wait-state memory, request to 0x10 outstanding, `ex_b_flag=1`, `ex_b_addr=0x100` for one cycle:
  - `mem_addr` stays 0x10 until `mem_ready`.
  - The 0x10 data never appears on `if_inst`.
  - The next request is 0x100.
- `ex_b_flag` and `id_b_flag` asserted together with targets 0x200 and 0x300: next fetch is 0x200 and the slot is cleared to 0.
- Redirect to 0x40 in the same cycle as `mem_ready` for 0x20: the 0x20 data is dropped, the next-cycle `mem_addr` is 0x40, and there is no KILL cycle.
- Assert `rst` mid-wait on request 0x8:
  - The next cycle has `mem_req=0` and `if_pc=if_inst=0`.
  - After release, the fetch restarts at `RESET_PC`.
